fsm_calculator_multidigit: RTL and testbench
============================================

FSM_CALCULATOR_MULTIDIGIT -- requirements
Module: fsm_calculator_multidigit

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand, accumulator and result width in bits.
REQ-002 Parameter MAX_DIGITS, default 4, SHALL set the maximum number of decimal digits accepted per operand; the constraint 10^MAX_DIGITS-1 <= 2^WIDTH-1 SHALL hold.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 clear  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 num_valid  input  1  SHALL be a one-cycle strobe qualifying button_num.
REQ-006 button_num  input  4  SHALL be the digit; only values 0-9 are accepted, 10-15 are ignored.
REQ-007 op_valid  input  1  SHALL be a one-cycle strobe qualifying button_op.
REQ-008 button_op  input  3  SHALL encode 001 ADD, 010 SUB, 011 MUL, 100 DIV, 101 MOD; other codes are ignored.
REQ-009 equal  input  1  SHALL be a one-cycle strobe requesting evaluation.
REQ-010 display  output  WIDTH  SHALL be the operand being entered, or the result in DONE.
REQ-011 result  output  WIDTH  SHALL be the last evaluated result.
REQ-012 done  output  1  SHALL be a one-cycle pulse when result updates.
REQ-013 busy  output  1  SHALL be high while a divide/mod is iterating.
REQ-014 error  output  1  SHALL be high in ERROR state.
REQ-015 overflow  output  1  SHALL flag the last ADD/MUL result as truncated.

Function
REQ-016 States SHALL be IDLE, ENTER_A, ENTER_B, DIVIDE, DONE and ERROR.
REQ-017 Input priority in one cycle SHALL be clear > equal > op_valid > num_valid; lower-priority strobes in the same cycle are dropped.
REQ-018 Digit entry SHALL update acc <= acc*10 + digit and increment the digit count; digits beyond MAX_DIGITS are ignored.
REQ-019 IDLE: num_valid with a valid digit loads A = digit and goes to ENTER_A; op_valid and equal are ignored.
REQ-020 ENTER_A: digits extend A; a valid op latches the operation, clears B and the digit count, and goes to ENTER_B.
REQ-021 ENTER_B: digits extend B; a valid op before any B digit replaces the latched operation; equal with zero B digits is ignored.
REQ-022 ENTER_B + equal, ADD/SUB/MUL: result is computed combinationally and registered on that edge; done pulses the next cycle; state goes to DONE.
REQ-023 ADD SHALL produce (A+B) mod 2^WIDTH, with overflow set on carry-out.
REQ-024 MUL SHALL produce the low WIDTH bits of A*B, with overflow set if any high bit is nonzero.
REQ-025 SUB with B > A SHALL go to ERROR with result 0; otherwise the result is A-B.
REQ-026 DIV/MOD with B = 0 SHALL go to ERROR with result 0.
REQ-027 DIV/MOD with B != 0 SHALL enter DIVIDE and run a restoring shift-subtract loop for exactly WIDTH cycles with busy high; it then loads the quotient (DIV) or remainder (MOD), pulses done and goes to DONE.
REQ-028 While busy, num_valid, op_valid and equal SHALL be ignored.
REQ-029 DONE: a valid op SHALL chain by setting A = result, latching the op and going to ENTER_B; a digit SHALL start fresh with A = digit and overflow cleared, going to ENTER_A; equal is ignored.
REQ-030 ERROR: only a valid digit (start fresh, error cleared, go to ENTER_A) or clear SHALL leave the state.
REQ-031 overflow SHALL be cleared by every evaluation that does not overflow, and on entry to ERROR.

Reset
REQ-032 clear high at a clock edge SHALL set the state to IDLE; A, B, digit count, operation, display, result, done, busy, error and overflow all go to 0, overriding any state including DIVIDE mid-iteration.

Verification (WIDTH=16, MAX_DIGITS=4)
REQ-033 Digits 1,2,3, op ADD, digits 4,5, equal -> result 168, done high exactly one cycle, overflow 0.
REQ-034 Digits 9,9,9,9,9 -> display 9999 (fifth digit ignored).
REQ-035 Digits 1,0,0, DIV, 7, equal -> busy 16 cycles, result 14; then MOD, 5, equal -> result 4.
REQ-036 Digit 5, SUB, 9, equal -> error 1, result 0; then digit 3 -> error 0, display 3. Also 5 DIV 0 -> error 1.
REQ-037 Digits 3,0,0, MUL, 3,0,0, equal -> result 24464, overflow 1.
REQ-038 Start 100 DIV 7; assert clear in the 8th busy cycle -> next cycle state IDLE and all outputs 0. Also equal, op_valid and num_valid in one cycle in ENTER_B -> only the evaluation occurs.

Source files
------------

// File: rtl/fsm_calculator_multidigit.sv
// ---------------------------------------------------------------------------
// fsm_calculator_multidigit
//   Button-driven integer calculator. Operands are typed in as decimal digits
//   (up to MAX_DIGITS each), an operator is latched between them, and equal
//   evaluates. ADD/SUB/MUL complete in the equal cycle; DIV/MOD run a
//   restoring shift-subtract divider for exactly WIDTH cycles.
//
// Ports
//   clk         rising-edge clock
//   clear       synchronous active-high reset
//   num_valid   strobe qualifying button_num (digit 0-9, 10-15 ignored)
//   button_num  digit value
//   op_valid    strobe qualifying button_op
//   button_op   001 ADD, 010 SUB, 011 MUL, 100 DIV, 101 MOD
//   equal       strobe requesting evaluation
//   display     operand being entered, or result in DONE
//   result      last evaluated result
//   done        one-cycle pulse when result updates
//   busy        high while DIV/MOD iterates
//   error       high in ERROR state
//   overflow    last ADD/MUL result was truncated
// ---------------------------------------------------------------------------
module fsm_calculator_multidigit #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             num_valid,
    input  logic [3:0]       button_num,
    input  logic             op_valid,
    input  logic [2:0]       button_op,
    input  logic             equal,
    output logic [WIDTH-1:0] display,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             error,
    output logic             overflow
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int DW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER_A,
        S_ENTER_B,
        S_DIVIDE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    cnt;
    logic [2:0]       op;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [DW-1:0]    dcnt;

    logic             digit_ok;
    logic             op_ok;
    logic             room;
    logic [WIDTH-1:0] digit_val;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_sub;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] rem_n;

    always_comb begin
        digit_ok  = (button_num <= 4'd9);
        op_ok     = (button_op >= OP_ADD) && (button_op <= OP_MOD);
        room      = (cnt < CW'(MAX_DIGITS));
        digit_val = WIDTH'(button_num);
        // acc*10 + digit as shifts; MAX_DIGITS bounds the value so no wrap
        a_next    = (a << 3) + (a << 1) + digit_val;
        b_next    = (b << 3) + (b << 1) + digit_val;
        sum       = {1'b0, a} + {1'b0, b};
        prod      = (2*WIDTH)'(a) * (2*WIDTH)'(b);

        // One restoring step: shift the next dividend bit into the partial
        // remainder and subtract the divisor if it fits (sign bit clear).
        r_sh  = {rem, quo[WIDTH-1]};
        r_sub = r_sh - {1'b0, b};
        if (!r_sub[WIDTH]) begin
            rem_n = r_sub[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = r_sh[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= S_IDLE;
            a        <= '0;
            b        <= '0;
            cnt      <= '0;
            op       <= '0;
            quo      <= '0;
            rem      <= '0;
            dcnt     <= '0;
            display  <= '0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // equal/op are ignored here but still drop a same-cycle digit
                    if (!equal && !op_valid && num_valid && digit_ok) begin
                        a       <= digit_val;
                        cnt     <= CW'(1);
                        display <= digit_val;
                        state   <= S_ENTER_A;
                    end
                end

                S_ENTER_A: begin
                    if (equal) begin
                        // no second operand yet: nothing to evaluate
                    end else if (op_valid) begin
                        if (op_ok) begin
                            op      <= button_op;
                            b       <= '0;
                            cnt     <= '0;
                            display <= '0;
                            state   <= S_ENTER_B;
                        end
                    end else if (num_valid && digit_ok && room) begin
                        a       <= a_next;
                        cnt     <= cnt + CW'(1);
                        display <= a_next;
                    end
                end

                S_ENTER_B: begin
                    if (equal) begin
                        if (cnt != '0) begin
                            case (op)
                                OP_ADD: begin
                                    result   <= sum[WIDTH-1:0];
                                    display  <= sum[WIDTH-1:0];
                                    overflow <= sum[WIDTH];
                                    done     <= 1'b1;
                                    state    <= S_DONE;
                                end
                                OP_SUB: begin
                                    if (b > a) begin
                                        result   <= '0;
                                        display  <= '0;
                                        overflow <= 1'b0;
                                        error    <= 1'b1;
                                        state    <= S_ERROR;
                                    end else begin
                                        result   <= a - b;
                                        display  <= a - b;
                                        overflow <= 1'b0;
                                        done     <= 1'b1;
                                        state    <= S_DONE;
                                    end
                                end
                                OP_MUL: begin
                                    result   <= prod[WIDTH-1:0];
                                    display  <= prod[WIDTH-1:0];
                                    overflow <= |prod[2*WIDTH-1:WIDTH];
                                    done     <= 1'b1;
                                    state    <= S_DONE;
                                end
                                OP_DIV, OP_MOD: begin
                                    if (b == '0) begin
                                        result   <= '0;
                                        display  <= '0;
                                        overflow <= 1'b0;
                                        error    <= 1'b1;
                                        state    <= S_ERROR;
                                    end else begin
                                        quo   <= a;
                                        rem   <= '0;
                                        dcnt  <= '0;
                                        busy  <= 1'b1;
                                        state <= S_DIVIDE;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (op_valid) begin
                        // operator can still be changed until B has a digit
                        if (op_ok && cnt == '0)
                            op <= button_op;
                    end else if (num_valid && digit_ok && room) begin
                        b       <= b_next;
                        cnt     <= cnt + CW'(1);
                        display <= b_next;
                    end
                end

                S_DIVIDE: begin
                    // all buttons are ignored while iterating
                    quo  <= quo_n;
                    rem  <= rem_n;
                    dcnt <= dcnt + DW'(1);
                    if (dcnt == DW'(WIDTH - 1)) begin
                        result   <= (op == OP_DIV) ? quo_n : rem_n;
                        display  <= (op == OP_DIV) ? quo_n : rem_n;
                        overflow <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (equal) begin
                        // repeat-equal is not supported
                    end else if (op_valid) begin
                        if (op_ok) begin
                            a       <= result;
                            op      <= button_op;
                            b       <= '0;
                            cnt     <= '0;
                            display <= '0;
                            state   <= S_ENTER_B;
                        end
                    end else if (num_valid && digit_ok) begin
                        a        <= digit_val;
                        cnt      <= CW'(1);
                        display  <= digit_val;
                        overflow <= 1'b0;
                        state    <= S_ENTER_A;
                    end
                end

                S_ERROR: begin
                    if (!equal && !op_valid && num_valid && digit_ok) begin
                        a       <= digit_val;
                        cnt     <= CW'(1);
                        display <= digit_val;
                        error   <= 1'b0;
                        state   <= S_ENTER_A;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_calculator_multidigit.sv
// ---------------------------------------------------------------------------
// tb_fsm_calculator_multidigit
//   Self-checking bench for fsm_calculator_multidigit (WIDTH=16, MAX_DIGITS=4).
//   Expected results are pushed to a scoreboard queue when equal is pressed
//   and popped/compared when done is seen.
// ---------------------------------------------------------------------------
module tb_fsm_calculator_multidigit;

    logic        clk;
    logic        clear;
    logic        num_valid;
    logic [3:0]  button_num;
    logic        op_valid;
    logic [2:0]  button_op;
    logic        equal;
    logic [15:0] display;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        error;
    logic        overflow;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fsm_calculator_multidigit #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clk        (clk),
        .clear      (clear),
        .num_valid  (num_valid),
        .button_num (button_num),
        .op_valid   (op_valid),
        .button_op  (button_op),
        .equal      (equal),
        .display    (display),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .error      (error),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        num_valid = 1'b1; button_num = d;
        tick();
        num_valid = 1'b0;
    endtask

    task automatic press_op(input logic [2:0] o);
        op_valid = 1'b1; button_op = o;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic press_equal();
        equal = 1'b1;
        tick();
        equal = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        n_cmp++;
        if ({display, result, done, busy, error, overflow} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got disp=%0d res=%0d d=%b b=%b e=%b o=%b expected all 0",
                     display, result, done, busy, error, overflow);
        end
    endtask

    task automatic test_add();
        bit   got;
        exp_t e;
        do_clear();
        press_digit(1); press_digit(2); press_digit(3);
        n_cmp++;
        if (display !== 16'd123) begin
            n_bad++; $display("FAIL add_display_a: got %0d expected 123", display);
        end
        press_op(3'd1);
        press_digit(4); press_digit(5);
        exp_q.push_back('{res: 16'd168, ovf: 1'b0});
        press_equal();
        wait_done(5, got);
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL add_done: timeout waiting for done");
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== e.res || overflow !== e.ovf) begin
            n_bad++;
            $display("FAIL add_result: got %0d ovf=%b expected %0d ovf=%b", result, overflow, e.res, e.ovf);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL add_done_pulse: done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_digit_limit();
        do_clear();
        for (int i = 0; i < 5; i++) press_digit(9);
        n_cmp++;
        if (display !== 16'd9999) begin
            n_bad++; $display("FAIL digit_limit: got %0d expected 9999", display);
        end
        // out-of-range digit codes are ignored
        press_digit(4'd12);
        do_clear();
        press_digit(4'd11);
        press_digit(7);
        n_cmp++;
        if (display !== 16'd7) begin
            n_bad++; $display("FAIL digit_invalid: got %0d expected 7", display);
        end
    endtask

    task automatic test_divmod();
        int   n;
        exp_t e;
        do_clear();
        press_digit(1); press_digit(0); press_digit(0);
        press_op(3'd4);
        press_digit(7);
        exp_q.push_back('{res: 16'd14, ovf: 1'b0});
        press_equal();
        n = 0;
        while (busy && n < 100) begin
            // buttons are ignored while iterating
            num_valid = 1'b1; button_num = 4'd3;
            n++;
            tick();
        end
        num_valid = 1'b0;
        n_cmp++;
        if (n !== 16) begin
            n_bad++; $display("FAIL div_busy_cycles: got %0d expected 16", n);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL div_done: done=%b expected 1", done);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== e.res) begin
            n_bad++; $display("FAIL div_result: got %0d expected %0d", result, e.res);
        end
        press_op(3'd5);
        press_digit(5);
        exp_q.push_back('{res: 16'd4, ovf: 1'b0});
        press_equal();
        n = 0;
        while (!done && n < 40) begin
            n++;
            tick();
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (!done || result !== e.res) begin
            n_bad++; $display("FAIL mod_result: got %0d done=%b expected %0d", result, done, e.res);
        end
    endtask

    task automatic test_errors();
        do_clear();
        press_digit(5); press_op(3'd2); press_digit(9);
        press_equal();
        tick();
        n_cmp++;
        if (error !== 1'b1 || result !== 16'd0) begin
            n_bad++; $display("FAIL sub_error: got err=%b res=%0d expected err=1 res=0", error, result);
        end
        // ops and equal do not leave ERROR
        press_op(3'd1);
        press_equal();
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++; $display("FAIL error_sticky: got err=%b expected 1", error);
        end
        press_digit(3);
        n_cmp++;
        if (error !== 1'b0 || display !== 16'd3) begin
            n_bad++; $display("FAIL error_recover: got err=%b disp=%0d expected err=0 disp=3", error, display);
        end
        do_clear();
        press_digit(5); press_op(3'd4); press_digit(0);
        press_equal();
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || result !== 16'd0) begin
            n_bad++; $display("FAIL div_zero: got err=%b busy=%b res=%0d expected err=1 busy=0 res=0",
                              error, busy, result);
        end
    endtask

    task automatic test_mul();
        bit   got;
        exp_t e;
        do_clear();
        press_digit(3); press_digit(0); press_digit(0);
        press_op(3'd3);
        press_digit(3); press_digit(0); press_digit(0);
        exp_q.push_back('{res: 16'd24464, ovf: 1'b1});
        press_equal();
        wait_done(5, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || result !== e.res || overflow !== e.ovf) begin
            n_bad++;
            $display("FAIL mul_overflow: got %0d ovf=%b done=%b expected %0d ovf=%b",
                     result, overflow, got, e.res, e.ovf);
        end
        press_digit(1);
        n_cmp++;
        if (overflow !== 1'b0 || display !== 16'd1) begin
            n_bad++; $display("FAIL fresh_clears_ovf: got ovf=%b disp=%0d expected ovf=0 disp=1", overflow, display);
        end
    endtask

    task automatic test_clear_divide();
        do_clear();
        press_digit(1); press_digit(0); press_digit(0);
        press_op(3'd4);
        press_digit(7);
        press_equal();
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL clear_mid_busy: busy=%b before clear, expected 1", busy);
        end
        do_clear();
        n_cmp++;
        if ({display, result, done, busy, error, overflow} !== 36'd0) begin
            n_bad++;
            $display("FAIL clear_mid_div: got disp=%0d res=%0d d=%b b=%b e=%b o=%b expected all 0",
                     display, result, done, busy, error, overflow);
        end
        // in IDLE op is ignored, a digit starts entry
        press_op(3'd1);
        press_digit(2);
        n_cmp++;
        if (display !== 16'd2 || busy !== 1'b0) begin
            n_bad++; $display("FAIL clear_then_idle: got disp=%0d busy=%b expected disp=2 busy=0", display, busy);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        do_clear();
        press_digit(6); press_op(3'd1); press_digit(2);
        exp_q.push_back('{res: 16'd8, ovf: 1'b0});
        equal = 1'b1; op_valid = 1'b1; button_op = 3'd3; num_valid = 1'b1; button_num = 4'd9;
        tick();
        equal = 1'b0; op_valid = 1'b0; num_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || result !== e.res) begin
            n_bad++; $display("FAIL priority_eval: got %0d done=%b expected %0d done=1", result, done, e.res);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // continues from DONE with result 8
        press_op(3'd1); press_digit(5);
        exp_q.push_back('{res: 16'd13, ovf: 1'b0});
        press_equal();
        e = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || result !== e.res) begin
            n_bad++; $display("FAIL chain_add: got %0d done=%b expected %0d", result, done, e.res);
        end
        press_op(3'd2); press_digit(3);
        exp_q.push_back('{res: 16'd10, ovf: 1'b0});
        press_equal();
        e = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || result !== e.res) begin
            n_bad++; $display("FAIL chain_sub: got %0d done=%b expected %0d", result, done, e.res);
        end
        press_op(3'd3);
        press_equal();
        n_cmp++;
        if (done !== 1'b0 || result !== 16'd10) begin
            n_bad++; $display("FAIL equal_no_b: got done=%b res=%0d expected done=0 res=10", done, result);
        end
        press_op(3'd1);
        press_digit(7);
        press_op(3'd3);
        exp_q.push_back('{res: 16'd17, ovf: 1'b0});
        press_equal();
        e = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || result !== e.res) begin
            n_bad++; $display("FAIL op_replace: got %0d done=%b expected %0d", result, done, e.res);
        end
    endtask

    initial begin
        clear = 1'b0; num_valid = 1'b0; button_num = '0;
        op_valid = 1'b0; button_op = '0; equal = 1'b0;
        test_reset();
        test_add();
        test_digit_limit();
        test_divmod();
        test_errors();
        test_mul();
        test_clear_divide();
        test_priority();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
